// File: rtl/rom_map_pkg.sv
// rom_map_pkg: download map limits, region codes, FSM encoding and default image length
package rom_map_pkg;
   localparam logic [17:0] IMG_LEN_DEF = 18'h24220;
   localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_DRAIN = 2'd2, S_FIN = 2'd3;
   localparam logic [17:0] MAIN_BASE = 18'h00000, MAIN_LIM = 18'h0FFFF;
   localparam logic [17:0] SPRITE_BASE = 18'h10000, SPRITE_LIM = 18'h1FFFF;
   localparam logic [17:0] BG_BASE = 18'h20000, BG_LIM = 18'h23FFF;
   localparam logic [17:0] SPCLUT_BASE = 18'h24000, SPCLUT_LIM = 18'h240FF;
   localparam logic [17:0] BGCLUT_BASE = 18'h24100, BGCLUT_LIM = 18'h241FF;
   localparam logic [17:0] PAL_BASE = 18'h24200, PAL_LIM = 18'h2421F;
   localparam logic [2:0] R_MAIN = 3'd0, R_SPRITE = 3'd1, R_BG = 3'd2, R_SPCLUT = 3'd3,
                          R_BGCLUT = 3'd4, R_PAL = 3'd5, R_NONE = 3'd7;
   function automatic logic [2:0] region(input logic [17:0] a);
      return (a == MAIN_BASE || a <= MAIN_LIM) ? R_MAIN :
             (a >= SPRITE_BASE && a <= SPRITE_LIM) ? R_SPRITE :
             (a >= BG_BASE && a <= BG_LIM) ? R_BG :
             (a >= SPCLUT_BASE && a <= SPCLUT_LIM) ? R_SPCLUT :
             (a >= BGCLUT_BASE && a <= BGCLUT_LIM) ? R_BGCLUT :
             (a >= PAL_BASE && a <= PAL_LIM) ? R_PAL : R_NONE;
   endfunction
endpackage

// File: rtl/dl_byte_fifo.sv
// dl_byte_fifo: 2**FIFO_AW byte FIFO (clk, rst async, sync flush, push/din, pop/dout, full, empty)
module dl_byte_fifo #(
   parameter int FIFO_AW = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       flush,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       full,
   output logic       empty
);
   logic [7:0] mem [2**FIFO_AW];
   logic [FIFO_AW:0] wp, rp;
   logic do_push, do_pop;
   assign empty = wp == rp;
   assign full = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
   assign dout = mem[rp[FIFO_AW-1:0]];
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wp <= '0;
         rp <= '0;
      end else if (flush) begin
         wp <= '0;
         rp <= '0;
      end else begin
         wp <= do_push ? wp + 1'b1 : wp;
         rp <= do_pop ? rp + 1'b1 : rp;
      end
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wp[FIFO_AW-1:0]] <= din;
endmodule

// File: rtl/rom_dl_writer.sv
// rom_dl_writer: streams IMG_LEN source bytes (SV/SR/SD) into download writes (DLAD/DLDT/DLEN) with gap pacing, SUM, ERR, RGN
module rom_dl_writer
   import rom_map_pkg::*;
#(
   parameter logic [17:0] IMG_LEN = IMG_LEN_DEF,
   parameter int          WR_GAP  = 1,
   parameter int          FIFO_AW = 2
) (
   input  logic        CL,
   input  logic        RST,
   input  logic        START,
   input  logic        ABORT,
   input  logic        SV,
   input  logic [7:0]  SD,
   output logic        SR,
   output logic [17:0] DLAD,
   output logic [7:0]  DLDT,
   output logic        DLEN,
   output logic [2:0]  RGN,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERR,
   output logic [15:0] SUM
);
   logic [1:0] state;
   logic [17:0] acc, wcnt;
   logic [3:0] gap;
   logic [7:0] dout;
   logic full, empty, pop, push, go;
   assign go = START && !ABORT && (state == S_IDLE || state == S_FIN);
   assign pop = !empty && gap == 4'd0 && !ABORT;
   assign SR = state == S_LOAD && acc < IMG_LEN && (!full || pop);
   assign push = SV && SR;
   assign BUSY = state == S_LOAD || state == S_DRAIN;
   assign DONE = state == S_FIN;
   assign RGN = region(DLAD);
   dl_byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .clk(CL), .rst(RST), .flush(ABORT || go), .push(push), .pop(pop),
      .din(SD), .dout(dout), .full(full), .empty(empty)
   );
   always_ff @(posedge CL or posedge RST)
      if (RST) begin
         state <= S_IDLE;
         acc <= '0;
         wcnt <= '0;
         gap <= '0;
         DLAD <= '0;
         DLDT <= '0;
         DLEN <= 1'b0;
         SUM <= '0;
         ERR <= 1'b0;
      end else begin
         DLEN <= pop;
         if (pop) begin
            DLAD <= wcnt;
            DLDT <= dout;
            SUM <= SUM + {8'h00, dout};
            wcnt <= wcnt == IMG_LEN - 18'd1 ? wcnt : wcnt + 18'd1;
         end
         gap <= pop ? 4'(WR_GAP - 1) : gap != 4'd0 ? gap - 4'd1 : gap;
         if (SV && !SR && (state == S_DRAIN || state == S_FIN)) ERR <= 1'b1;
         if (push) acc <= acc + 18'd1;
         if (ABORT) state <= S_IDLE;
         else if (go) begin
            state <= S_LOAD;
            acc <= '0;
            wcnt <= '0;
            gap <= '0;
            SUM <= '0;
            ERR <= 1'b0;
         end else if (state == S_LOAD && push && acc == IMG_LEN - 18'd1) state <= S_DRAIN;
         else if (state == S_DRAIN && empty && !DLEN) state <= S_FIN;
      end
endmodule

// File: tb/tb_rom_dl_writer.sv
// tb_rom_dl_writer: directed/table checks of rom_dl_writer streaming, pacing, abort, reset and region map
module tb_rom_dl_writer;
   import rom_map_pkg::*;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic a_start = 0, a_abort = 0, a_sv = 0, a_sr, a_dlen, a_busy, a_done, a_err;
   logic [7:0] a_sd = 0, a_dldt;
   logic [17:0] a_dlad;
   logic [2:0] a_rgn;
   logic [15:0] a_sum;
   logic b_start = 0, b_abort = 0, b_sv = 0, b_sr, b_dlen, b_busy, b_done, b_err;
   logic [7:0] b_sd = 0, b_dldt;
   logic [17:0] b_dlad;
   logic [2:0] b_rgn;
   logic [15:0] b_sum;
   rom_dl_writer #(.IMG_LEN(18'd200), .WR_GAP(1), .FIFO_AW(2)) ua (
      .CL(clk), .RST(rst), .START(a_start), .ABORT(a_abort), .SV(a_sv), .SD(a_sd), .SR(a_sr),
      .DLAD(a_dlad), .DLDT(a_dldt), .DLEN(a_dlen), .RGN(a_rgn), .BUSY(a_busy), .DONE(a_done),
      .ERR(a_err), .SUM(a_sum)
   );
   rom_dl_writer #(.IMG_LEN(18'd16), .WR_GAP(4), .FIFO_AW(2)) ub (
      .CL(clk), .RST(rst), .START(b_start), .ABORT(b_abort), .SV(b_sv), .SD(b_sd), .SR(b_sr),
      .DLAD(b_dlad), .DLDT(b_dldt), .DLEN(b_dlen), .RGN(b_rgn), .BUSY(b_busy), .DONE(b_done),
      .ERR(b_err), .SUM(b_sum)
   );
   int passed = 0, total = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic samp;
      @(negedge clk);
      #1;
   endtask
   int cyc = 0;
   always @(posedge clk) cyc++;
   int a_np = 0, a_base = 0, a_bad = 0;
   logic [7:0] a_off = 0;
   logic [17:0] a_last = 0;
   always @(negedge clk)
      if (a_dlen) begin
         if (a_dlad !== 18'(a_np - a_base) || a_dldt !== 8'(a_np - a_base) + a_off) a_bad++;
         a_last = a_dlad;
         a_np++;
      end
   int b_np = 0, b_bad = 0, b_gapbad = 0, b_lastcyc = 0;
   always @(negedge clk)
      if (b_dlen) begin
         if (b_np > 0 && cyc - b_lastcyc != 4) b_gapbad++;
         if (b_dldt !== 8'hFF || b_dlad !== 18'(b_np)) b_bad++;
         b_lastcyc = cyc;
         b_np++;
      end
   function automatic logic [15:0] model_sum(input logic [7:0] off, input int n);
      logic [15:0] s = 0;
      for (int i = 0; i < n; i++) s = s + {8'h00, 8'(i) + off};
      return s;
   endfunction
   task automatic run_a(input logic [7:0] off, input int stop_at);
      int sent = 0;
      logic x;
      a_base = a_np;
      a_off = off;
      a_start = 1;
      tick;
      a_start = 0;
      a_sd = off;
      a_sv = 1;
      for (int k = 0; k < 2000 && !a_done && !(stop_at >= 0 && sent == stop_at); k++) begin
         samp;
         x = a_sr && a_sv;
         tick;
         if (x) begin
            sent++;
            a_sd = 8'(sent) + off;
            if (sent == 200) a_sv = 0;
         end
         a_start = x && sent == 50;
      end
      a_sv = 0;
      a_start = 0;
   endtask
   typedef struct {logic [17:0] a; logic [2:0] r;} rvec_t;
   rvec_t rv [14];
   initial begin
      int acc, lo_acc, lo_np;
      logic x;
      rv = '{'{18'h00000, 3'd0}, '{18'h0FFFF, 3'd0}, '{18'h10000, 3'd1}, '{18'h1FFFF, 3'd1},
             '{18'h20000, 3'd2}, '{18'h23FFF, 3'd2}, '{18'h24000, 3'd3}, '{18'h240FF, 3'd3},
             '{18'h24100, 3'd4}, '{18'h241FF, 3'd4}, '{18'h24200, 3'd5}, '{18'h2421F, 3'd5},
             '{18'h24220, 3'd7}, '{18'h3FFFF, 3'd7}};
      for (int i = 0; i < 14; i++) chk($sformatf("rgn[%05h]", rv[i].a), region(rv[i].a), rv[i].r);
      repeat (3) tick;
      samp;
      chk("rst dlen", a_dlen, 0);
      chk("rst dlad", a_dlad, 0);
      chk("rst sr", a_sr, 0);
      chk("rst busy/done/err", {a_busy, a_done, a_err}, 0);
      chk("rst sum", a_sum, 0);
      chk("rst rgn", a_rgn, 0);
      chk("rst b dlen/sum", {b_dlen, b_sum}, 0);
      rst = 0;
      tick;
      run_a(8'h00, -1);
      samp;
      chk("full done", a_done, 1);
      chk("full writes", a_np - a_base, 200);
      chk("full last dlad", a_last, 18'd199);
      chk("full err", a_err, 0);
      chk("full data/addr seq", a_bad, 0);
      chk("full sum", a_sum, model_sum(8'h00, 200));
      chk("full busy/sr", {a_busy, a_sr}, 0);
      chk("full rgn", a_rgn, 0);
      run_a(8'h10, 100);
      samp;
      chk("pre-abort dlen", a_dlen, 1);
      a_abort = 1;
      tick;
      a_abort = 0;
      chk("abort dlen", a_dlen, 0);
      chk("abort busy", a_busy, 0);
      chk("abort seq", a_bad, 0);
      chk("abort no overrun", a_np - a_base <= 100, 1);
      repeat (3) tick;
      chk("abort idle dlen", a_dlen, 0);
      run_a(8'h40, -1);
      samp;
      chk("restart done", a_done, 1);
      chk("restart writes", a_np - a_base, 200);
      chk("restart seq from 0", a_bad, 0);
      chk("restart sum", a_sum, model_sum(8'h40, 200));
      run_a(8'h00, 30);
      #2;
      chk("pre-rst dlen", a_dlen, 1);
      rst = 1;
      #1;
      chk("async rst dlen", a_dlen, 0);
      tick;
      tick;
      rst = 0;
      samp;
      chk("post-rst dlad/dldt", {a_dlad, a_dldt}, 0);
      chk("post-rst sum", a_sum, 0);
      chk("post-rst flags", {a_busy, a_done, a_err, a_sr, a_dlen}, 0);
      chk("post-rst rgn", a_rgn, 0);
      repeat (5) tick;
      chk("no restart w/o start", {a_busy, a_dlen}, 0);
      run_a(8'h07, -1);
      samp;
      chk("after-rst run", {a_done, a_err}, 2'b10);
      chk("after-rst seq", a_bad, 0);
      b_start = 1;
      tick;
      b_start = 0;
      b_sd = 8'hFF;
      b_sv = 1;
      acc = 0;
      lo_acc = -1;
      lo_np = -1;
      for (int k = 0; k < 500 && !b_done; k++) begin
         samp;
         x = b_sr && b_sv;
         if (b_sv && !b_sr && lo_acc < 0) begin
            lo_acc = acc;
            lo_np = b_np;
         end
         tick;
         if (x) begin
            acc++;
            if (acc == 16) b_sv = 0;
         end
      end
      samp;
      chk("gap done", b_done, 1);
      chk("gap sr-low accepted", lo_acc, 6);
      chk("gap sr-low writes", lo_np, 2);
      chk("gap writes", b_np, 16);
      chk("gap spacing", b_gapbad, 0);
      chk("gap data", b_bad, 0);
      chk("gap sum", b_sum, 16'h0FF0);
      chk("gap err pre", b_err, 0);
      b_sv = 1;
      b_sd = 8'h55;
      samp;
      chk("extra sr", b_sr, 0);
      tick;
      b_sv = 0;
      repeat (10) tick;
      samp;
      chk("extra err", b_err, 1);
      chk("extra no write", b_np, 16);
      chk("extra sum", b_sum, 16'h0FF0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
